// File: rtl/alu4_pkg.sv
// Shared opcode definitions for the 4-bit registered ALU.
// Imported by the top level and by any harness that drives op.
package alu4_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_NOTA = 3'b000;
    localparam opcode_t OP_NOTB = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_XOR  = 3'b100;
    localparam opcode_t OP_XNOR = 3'b101;
    localparam opcode_t OP_ADD  = 3'b110;
    localparam opcode_t OP_SUB  = 3'b111;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder.
// Also exports the carry into bit 3 so callers can derive signed overflow.
module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = x ^ y;
    assign g = x & y;

    // Each carry is a flat sum of generate/propagate terms.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/alu4_sync.sv
// 4-bit ALU with registered result and carry/negative/zero/overflow flags.
// Captures on every rising clock; asynchronous active-high reset clears all outputs.
module alu4_sync
    import alu4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       c,
    output logic       n,
    output logic       z,
    output logic       v
);

    logic       is_sub;
    logic [3:0] add_y;
    logic [3:0] sum;
    logic       sum_co;
    logic       sum_c3;

    logic [3:0] result_d, result_q;
    logic       c_d, c_q;
    logic       n_d, n_q;
    logic       z_d, z_q;
    logic       v_d, v_q;

    // Subtraction reuses the adder as a + ~b + 1.
    assign is_sub = (op == OP_SUB);
    assign add_y  = is_sub ? ~b : b;

    cla4 u_cla4 (
        .x  (a),
        .y  (add_y),
        .ci (is_sub),
        .s  (sum),
        .co (sum_co),
        .c3 (sum_c3)
    );

    always_comb begin
        result_d = 4'b0000;
        c_d      = 1'b0;
        v_d      = 1'b0;
        case (op)
            OP_NOTA: result_d = ~a;
            OP_NOTB: result_d = ~b;
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_XOR:  result_d = a ^ b;
            OP_XNOR: result_d = ~(a ^ b);
            OP_ADD, OP_SUB: begin
                result_d = sum;
                c_d      = sum_co;
                // Carry into MSB differing from carry out is signed overflow for both add and sub.
                v_d      = sum_c3 ^ sum_co;
            end
            default: result_d = 4'b0000;
        endcase
        n_d = result_d[3];
        z_d = (result_d == 4'b0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 4'b0000;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            result_q <= result_d;
            c_q      <= c_d;
            n_q      <= n_d;
            z_q      <= z_d;
            v_q      <= v_d;
        end
    end

    assign result = result_q;
    assign c      = c_q;
    assign n      = n_q;
    assign z      = z_q;
    assign v      = v_q;

endmodule

// File: tb/tb_alu4_sync.sv
// Directed bench for alu4_sync; outputs compared as {result, c, n, z, v}.
`timescale 1ns/1ps
module tb_alu4_sync;

    logic       clk;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] result;
    logic       c, n, z, v;

    int checks;
    int errors;

    alu4_sync dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .c      (c),
        .n      (n),
        .z      (z),
        .v      (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got res=%b cnzv=%b, expected res=%b cnzv=%b",
                     tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    function automatic logic [7:0] outs();
        return {result, c, n, z, v};
    endfunction

    // Drive between edges, capture on the next rising edge, sample 1ns later.
    task automatic apply(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic [2:0] opv, input logic [7:0] exp);
        @(negedge clk);
        a  = av;
        b  = bv;
        op = opv;
        @(posedge clk);
        #1;
        check_eq(tag, outs(), exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a      = 4'b1011;
        b      = 4'b0110;
        op     = 3'b110;

        // Held in reset across several edges.
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_hold", outs(), 8'b0000_0000);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_capture_add", outs(), 8'b0001_1000);

        // Logic sweep, a=1011 b=0110.
        apply("nota", 4'b1011, 4'b0110, 3'b000, 8'b0100_0000);
        apply("notb", 4'b1011, 4'b0110, 3'b001, 8'b1001_0100);
        apply("and",  4'b1011, 4'b0110, 3'b010, 8'b0010_0000);
        apply("or",   4'b1011, 4'b0110, 3'b011, 8'b1111_0100);
        apply("xor",  4'b1011, 4'b0110, 3'b100, 8'b1101_0100);
        apply("xnor", 4'b1011, 4'b0110, 3'b101, 8'b0010_0000);
        apply("and_zero", 4'b1010, 4'b0101, 3'b010, 8'b0000_0010);

        // Arithmetic.
        apply("add_carry",   4'b1011, 4'b0110, 3'b110, 8'b0001_1000);
        apply("add_ovf",     4'b0111, 4'b0001, 3'b110, 8'b1000_0101);
        apply("add_zero",    4'b1000, 4'b1000, 3'b110, 8'b0000_1011);
        apply("add_plain",   4'b0010, 4'b0011, 3'b110, 8'b0101_0000);
        apply("sub_ovf",     4'b1011, 4'b0110, 3'b111, 8'b0101_1001);
        apply("sub_borrow",  4'b0010, 4'b0101, 3'b111, 8'b1101_0100);
        apply("sub_zero",    4'b0101, 4'b0101, 3'b111, 8'b0000_1010);
        apply("sub_wrap",    4'b0000, 4'b0001, 3'b111, 8'b1111_0100);
        apply("sub_minovf",  4'b1000, 4'b0001, 3'b111, 8'b0111_1001);

        // Inputs changed between edges must not reach outputs until the next edge.
        @(negedge clk);
        a  = 4'b0111;
        b  = 4'b0001;
        op = 3'b110;
        #2;
        check_eq("latency_hold", outs(), 8'b0111_1001);
        @(posedge clk);
        #1;
        check_eq("latency_update", outs(), 8'b1000_0101);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset", outs(), 8'b0000_0000);
        @(posedge clk);
        #1;
        check_eq("async_reset_hold", outs(), 8'b0000_0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_reset_capture", outs(), 8'b1000_0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
